// File: rtl/hazard_scoreboard_pkg.sv
// rtl/hazard_scoreboard_pkg.sv - latency classes, forward-select encoding and branch FSM states
package hazard_scoreboard_pkg;

   localparam int LAT_ALU    = 1;
   localparam int LAT_LOAD   = 2;
   localparam int LAT_MUL    = 3;
   localparam int FWD_SEL_RF = 0;
   localparam int BR_CNT_W   = 4;

   typedef enum logic {
      BR_IDLE,
      BR_SHADOW
   } br_state_e;

endpackage

// File: rtl/hazard_scoreboard_if.sv
// rtl/hazard_scoreboard_if.sv - ID-stage request and hazard response bundle
interface hazard_scoreboard_if #(
   parameter int REG_AW    = 5,
   parameter int LAT_W     = 2,
   parameter int FWD_SEL_W = 2,
   parameter int CNT_W     = 32
);
   logic              id_valid;
   logic [REG_AW-1:0] id_rs;
   logic [REG_AW-1:0] id_rt;
   logic              id_rs_used;
   logic              id_rt_used;
   logic              id_wreg;
   logic [REG_AW-1:0] id_dest;
   logic [LAT_W-1:0]  id_lat;
   logic              id_branch_taken;
   logic              flush;

   logic                 stall;
   logic [FWD_SEL_W-1:0] fwda;
   logic [FWD_SEL_W-1:0] fwdb;
   logic                 cancel_next;
   logic                 issue;
   logic [CNT_W-1:0]     stall_count;

   modport master (
      output id_valid, id_rs, id_rt, id_rs_used, id_rt_used, id_wreg, id_dest, id_lat,
             id_branch_taken, flush,
      input  stall, fwda, fwdb, cancel_next, issue, stall_count
   );

   modport slave (
      input  id_valid, id_rs, id_rt, id_rs_used, id_rt_used, id_wreg, id_dest, id_lat,
             id_branch_taken, flush,
      output stall, fwda, fwdb, cancel_next, issue, stall_count
   );

endinterface

// File: rtl/hazard_scoreboard_match.sv
// rtl/hazard_scoreboard_match.sv - youngest-writer search for one source operand
module hazard_scoreboard_match #(
   parameter int REG_AW    = 5,
   parameter int FWD_DEPTH = 3,
   parameter int LAT_W     = 2,
   parameter int IDX_W     = 2
) (
   input  logic [REG_AW-1:0]                 addr_i,
   input  logic                              used_i,
   input  logic [FWD_DEPTH-1:0]              valid_i,
   input  logic [FWD_DEPTH-1:0]              wreg_i,
   input  logic [FWD_DEPTH-1:0][REG_AW-1:0]  dest_i,
   input  logic [FWD_DEPTH-1:0][LAT_W-1:0]   rem_i,
   output logic                              hit_o,
   output logic [IDX_W-1:0]                  idx_o,
   output logic                              not_ready_o
);

   // Walk oldest to youngest so the lowest stage index wins the last assignment.
   always_comb begin
      hit_o       = 1'b0;
      idx_o       = '0;
      not_ready_o = 1'b0;
      if (used_i && (addr_i != '0)) begin
         for (int k = FWD_DEPTH - 1; k >= 0; k--) begin
            if (valid_i[k] && wreg_i[k] && (dest_i[k] == addr_i)) begin
               hit_o       = 1'b1;
               idx_o       = IDX_W'(k);
               not_ready_o = (rem_i[k] != '0);
            end
         end
      end
   end

endmodule

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - in-flight write tracking, stall/forward generation and branch shadow
module hazard_scoreboard
   import hazard_scoreboard_pkg::*;
#(
   parameter int REG_AW       = 5,
   parameter int FWD_DEPTH    = 3,
   parameter int LAT_W        = 2,
   parameter int BRANCH_SLOTS = 1,
   parameter int CNT_W        = 32
) (
   input  logic                clk,
   input  logic                rst,
   hazard_scoreboard_if.slave  bus
);

   localparam int FWD_SEL_W = $clog2(FWD_DEPTH + 1);
   localparam int LX_W      = LAT_W + 1;
   localparam logic [LX_W-1:0]     LAT_MIN = LX_W'(LAT_ALU);
   localparam logic [LX_W-1:0]     LAT_MAX = LX_W'(FWD_DEPTH);
   localparam logic [BR_CNT_W-1:0] BR_LOAD = BR_CNT_W'(BRANCH_SLOTS);

   logic [FWD_DEPTH-1:0]             valid_q, valid_d;
   logic [FWD_DEPTH-1:0]             wreg_q, wreg_d;
   logic [FWD_DEPTH-1:0][REG_AW-1:0] dest_q, dest_d;
   logic [FWD_DEPTH-1:0][LAT_W-1:0]  rem_q, rem_d;
   br_state_e                        state_q, state_d;
   logic [BR_CNT_W-1:0]              cnt_q, cnt_d;
   logic [CNT_W-1:0]                 stall_cnt_q, stall_cnt_d;

   logic                 rs_hit, rs_nr, rt_hit, rt_nr;
   logic [FWD_SEL_W-1:0] rs_idx, rt_idx;
   logic                 cancel, stall, issue;
   logic [LX_W-1:0]      lat_ext, lat_eff;
   logic [LAT_W-1:0]     rem0;

   hazard_scoreboard_match #(
      .REG_AW(REG_AW), .FWD_DEPTH(FWD_DEPTH), .LAT_W(LAT_W), .IDX_W(FWD_SEL_W)
   ) u_match_rs (
      .addr_i(bus.id_rs), .used_i(bus.id_rs_used), .valid_i(valid_q), .wreg_i(wreg_q),
      .dest_i(dest_q), .rem_i(rem_q), .hit_o(rs_hit), .idx_o(rs_idx), .not_ready_o(rs_nr)
   );

   hazard_scoreboard_match #(
      .REG_AW(REG_AW), .FWD_DEPTH(FWD_DEPTH), .LAT_W(LAT_W), .IDX_W(FWD_SEL_W)
   ) u_match_rt (
      .addr_i(bus.id_rt), .used_i(bus.id_rt_used), .valid_i(valid_q), .wreg_i(wreg_q),
      .dest_i(dest_q), .rem_i(rem_q), .hit_o(rt_hit), .idx_o(rt_idx), .not_ready_o(rt_nr)
   );

   // Latency is clamped into 1..FWD_DEPTH so rem never outlives the tracked window.
   assign lat_ext = {1'b0, bus.id_lat};
   assign lat_eff = (lat_ext < LAT_MIN) ? LAT_MIN : ((lat_ext > LAT_MAX) ? LAT_MAX : lat_ext);
   assign rem0    = LAT_W'(lat_eff - LAT_MIN);

   assign cancel = (state_q == BR_SHADOW);
   assign stall  = bus.id_valid & ~cancel & ((rs_hit & rs_nr) | (rt_hit & rt_nr));
   assign issue  = bus.id_valid & ~stall & ~cancel & ~bus.flush;

   assign bus.stall       = stall;
   assign bus.cancel_next = cancel;
   assign bus.issue       = issue;
   assign bus.stall_count = stall_cnt_q;
   assign bus.fwda = (rs_hit && !rs_nr) ? rs_idx + FWD_SEL_W'(1) : FWD_SEL_W'(FWD_SEL_RF);
   assign bus.fwdb = (rt_hit && !rt_nr) ? rt_idx + FWD_SEL_W'(1) : FWD_SEL_W'(FWD_SEL_RF);

   always_comb begin
      valid_d = '0;
      wreg_d  = '0;
      dest_d  = '0;
      rem_d   = '0;
      if (!bus.flush) begin
         valid_d[0] = issue;
         wreg_d[0]  = bus.id_wreg;
         dest_d[0]  = bus.id_dest;
         rem_d[0]   = rem0;
         for (int k = 1; k < FWD_DEPTH; k++) begin
            valid_d[k] = valid_q[k-1];
            wreg_d[k]  = wreg_q[k-1];
            dest_d[k]  = dest_q[k-1];
            rem_d[k]   = (rem_q[k-1] == '0) ? '0 : rem_q[k-1] - LAT_W'(1);
         end
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (bus.flush) begin
         state_d = BR_IDLE;
         cnt_d   = '0;
      end else begin
         case (state_q)
            BR_IDLE: begin
               if (bus.id_branch_taken && issue) begin
                  state_d = BR_SHADOW;
                  cnt_d   = BR_LOAD;
               end
            end
            BR_SHADOW: begin
               cnt_d = (cnt_q == '0) ? '0 : cnt_q - BR_CNT_W'(1);
               if (cnt_q <= BR_CNT_W'(1)) begin
                  state_d = BR_IDLE;
               end
            end
            default: begin
               state_d = BR_IDLE;
               cnt_d   = '0;
            end
         endcase
      end
   end

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (stall && !(&stall_cnt_q)) begin
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q     <= '0;
         wreg_q      <= '0;
         dest_q      <= '0;
         rem_q       <= '0;
         state_q     <= BR_IDLE;
         cnt_q       <= '0;
         stall_cnt_q <= '0;
      end else begin
         valid_q     <= valid_d;
         wreg_q      <= wreg_d;
         dest_q      <= dest_d;
         rem_q       <= rem_d;
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   a_lat_legal: assert property (@(posedge clk) disable iff (rst)
      (bus.id_valid && bus.id_wreg) |-> (lat_ext <= LAT_MAX));

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb/tb_hazard_scoreboard.sv - directed vectors for stall, forwarding, branch shadow, flush and reset
module tb_hazard_scoreboard;
   import hazard_scoreboard_pkg::*;

   logic clk = 1'b0;
   logic rst;
   int   n_checks = 0;
   int   n_fail   = 0;

   always #5 clk = ~clk;

   hazard_scoreboard_if #(.REG_AW(5), .LAT_W(2), .FWD_SEL_W(2), .CNT_W(32)) hz();

   hazard_scoreboard #(
      .REG_AW(5), .FWD_DEPTH(3), .LAT_W(2), .BRANCH_SLOTS(2), .CNT_W(32)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(hz)
   );

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic set_in(input logic v, input logic [4:0] rs, input logic ru,
                         input logic [4:0] rt, input logic rtu, input logic w,
                         input logic [4:0] d, input logic [1:0] lat,
                         input logic br, input logic fl);
      hz.id_valid        = v;
      hz.id_rs           = rs;
      hz.id_rs_used      = ru;
      hz.id_rt           = rt;
      hz.id_rt_used      = rtu;
      hz.id_wreg         = w;
      hz.id_dest         = d;
      hz.id_lat          = lat;
      hz.id_branch_taken = br;
      hz.flush           = fl;
   endtask

   task automatic drive(input logic v, input logic [4:0] rs, input logic ru,
                        input logic [4:0] rt, input logic rtu, input logic w,
                        input logic [4:0] d, input logic [1:0] lat,
                        input logic br, input logic fl);
      @(negedge clk);
      set_in(v, rs, ru, rt, rtu, w, d, lat, br, fl);
      #1;
   endtask

   task automatic expect_out(input string tag, input logic st, input logic [1:0] fa,
                             input logic [1:0] fb, input logic cn, input logic is);
      check_eq({tag, ".stall"},  32'(hz.stall),       32'(st));
      check_eq({tag, ".fwda"},   32'(hz.fwda),        32'(fa));
      check_eq({tag, ".fwdb"},   32'(hz.fwdb),        32'(fb));
      check_eq({tag, ".cancel"}, 32'(hz.cancel_next), 32'(cn));
      check_eq({tag, ".issue"},  32'(hz.issue),       32'(is));
   endtask

   task automatic drain();
      for (int i = 0; i < 3; i++) drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      rst = 1'b1;
      set_in(1, 1, 1, 2, 1, 1, 3, 2'(LAT_ALU), 0, 0);
      #12;
      expect_out("reset", 0, 0, 0, 0, 1);
      check_eq("reset.stall_count", hz.stall_count, 0);
      set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      rst = 1'b0;

      // ALU result forwarded from EXE, then MEM
      drive(1, 1, 1, 2, 1, 1, 3, 2'(LAT_ALU), 0, 0); expect_out("t1_add_r3", 0, 0, 0, 0, 1);
      drive(1, 3, 1, 1, 1, 1, 4, 2'(LAT_ALU), 0, 0); expect_out("t1_use_exe", 0, 1, 0, 0, 1);
      drive(1, 3, 1, 0, 0, 1, 8, 2'(LAT_ALU), 0, 0); expect_out("t1_use_mem", 0, 2, 0, 0, 1);
      drain();
      drive(1, 1, 1, 0, 0, 1, 10, 0, 0, 0);          expect_out("lat0_wr", 0, 0, 0, 0, 1);
      drive(1, 10, 1, 0, 0, 0, 0, 2'(LAT_ALU), 0, 0); expect_out("lat0_use", 0, 1, 0, 0, 1);
      drain();

      // load-use: one stall, then MEM forward
      drive(1, 1, 1, 0, 0, 1, 5, 2'(LAT_LOAD), 0, 0); expect_out("t2_lw", 0, 0, 0, 0, 1);
      drive(1, 5, 1, 0, 1, 1, 6, 2'(LAT_ALU), 0, 0);  expect_out("t2_stall", 1, 0, 0, 0, 0);
      drive(1, 5, 1, 0, 1, 1, 6, 2'(LAT_ALU), 0, 0);  expect_out("t2_fwd", 0, 2, 0, 0, 1);
      check_eq("t2.stall_count", hz.stall_count, 1);
      drain();

      // multiply: two stalls, then WB forward on rt
      drive(1, 1, 1, 2, 1, 1, 7, 2'(LAT_MUL), 0, 0); expect_out("t3_mul", 0, 0, 0, 0, 1);
      drive(1, 1, 1, 7, 1, 0, 0, 2'(LAT_ALU), 0, 0); expect_out("t3_stall1", 1, 0, 0, 0, 0);
      drive(1, 1, 1, 7, 1, 0, 0, 2'(LAT_ALU), 0, 0); expect_out("t3_stall2", 1, 0, 0, 0, 0);
      drive(1, 1, 1, 7, 1, 0, 0, 2'(LAT_ALU), 0, 0); expect_out("t3_fwd", 0, 0, 3, 0, 1);
      check_eq("t3.stall_count", hz.stall_count, 3);
      drain();

      // youngest writer wins; r0 never matches even for a pending load
      drive(1, 1, 1, 0, 0, 1, 2, 2'(LAT_ALU), 0, 0);  expect_out("t4_add_r2", 0, 0, 0, 0, 1);
      drive(1, 1, 1, 0, 0, 1, 2, 2'(LAT_ALU), 0, 0);  expect_out("t4_sub_r2", 0, 0, 0, 0, 1);
      drive(1, 2, 1, 0, 0, 0, 0, 2'(LAT_ALU), 0, 0);  expect_out("t4_younger", 0, 1, 0, 0, 1);
      drive(1, 0, 0, 0, 0, 1, 0, 2'(LAT_LOAD), 0, 0); expect_out("t4_lw_r0", 0, 0, 0, 0, 1);
      drive(1, 0, 1, 2, 1, 0, 0, 2'(LAT_ALU), 0, 0);  expect_out("t4_r0_use", 0, 0, 3, 0, 1);
      drain();

      // two-slot branch shadow; squashed writer leaves no entry
      drive(1, 1, 1, 2, 1, 0, 0, 2'(LAT_ALU), 1, 0); expect_out("t5_beq", 0, 0, 0, 0, 1);
      drive(1, 1, 1, 0, 0, 1, 9, 2'(LAT_ALU), 0, 0); expect_out("t5_shadow1", 0, 0, 0, 1, 0);
      drive(1, 1, 1, 0, 0, 1, 9, 2'(LAT_ALU), 0, 0); expect_out("t5_shadow2", 0, 0, 0, 1, 0);
      drive(1, 9, 1, 0, 0, 0, 0, 2'(LAT_ALU), 0, 0); expect_out("t5_after", 0, 0, 0, 0, 1);
      drain();
      drive(1, 1, 1, 0, 0, 1, 5, 2'(LAT_LOAD), 0, 0); expect_out("t5_lw", 0, 0, 0, 0, 1);
      drive(1, 5, 1, 0, 0, 0, 0, 2'(LAT_ALU), 1, 0);  expect_out("t5_br_stall", 1, 0, 0, 0, 0);
      drive(1, 1, 1, 0, 0, 0, 0, 2'(LAT_ALU), 0, 0);  expect_out("t5_no_shadow", 0, 0, 0, 0, 1);
      check_eq("t5.stall_count", hz.stall_count, 4);
      drain();

      // flush clears a load-use stall; flush also blocks issue
      drive(1, 1, 1, 0, 0, 1, 5, 2'(LAT_LOAD), 0, 0); expect_out("t6_lw", 0, 0, 0, 0, 1);
      drive(1, 5, 1, 0, 0, 1, 6, 2'(LAT_ALU), 0, 1);  expect_out("t6_flush", 1, 0, 0, 0, 0);
      drive(1, 5, 1, 0, 0, 1, 6, 2'(LAT_ALU), 0, 0);  expect_out("t6_post_flush", 0, 0, 0, 0, 1);
      check_eq("t6.stall_count", hz.stall_count, 5);
      drain();
      drive(1, 1, 1, 0, 0, 1, 11, 2'(LAT_ALU), 0, 1); expect_out("t6_flush_issue", 0, 0, 0, 0, 0);
      drive(1, 11, 1, 0, 0, 0, 0, 2'(LAT_ALU), 0, 0); expect_out("t6_no_entry", 0, 0, 0, 0, 1);
      drain();

      // asynchronous reset in the middle of a shadow
      drive(1, 1, 1, 0, 0, 0, 0, 2'(LAT_ALU), 1, 0); expect_out("t6_br", 0, 0, 0, 0, 1);
      drive(1, 1, 1, 0, 0, 0, 0, 2'(LAT_ALU), 0, 0); expect_out("t6_shadow", 0, 0, 0, 1, 0);
      rst = 1'b1;
      #1;
      expect_out("t6_rst", 0, 0, 0, 0, 1);
      check_eq("t6_rst.stall_count", hz.stall_count, 0);
      @(negedge clk);
      rst = 1'b0;
      drive(1, 1, 1, 0, 0, 0, 0, 2'(LAT_ALU), 0, 0); expect_out("t6_post_rst", 0, 0, 0, 0, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
